multi_channel_timer: RTL and testbench

Parametrised multi-channel tick timer. It is the successor to the single-channel millisecond timer.
- A shared prescaler produces a global tick every CLKS_PER_TICK clocks, and every channel steps on that same tick.
- Each channel has its own direction, limit, one-shot/auto-reload mode, run enable, sticky done flag and expire pulse.
- Used by image send/select control for frame-interval, timeout and debounce timing from a single block.

---
 rtl/multi_channel_timer.sv | 116 +++++++++++
 tb/tb_multi_channel_timer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_timer.sv
// Multi-channel tick timer: one shared prescaler, NUM_CH up/down channels
// with one-shot or auto-reload mode, sticky done and expire pulse.
module multi_channel_timer #(
  parameter int NUM_CH        = 4,
  parameter int MAX_COUNT     = 2047,
  parameter int CLKS_PER_TICK = 50000,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int W    = $clog2(MAX_COUNT + 1),
  localparam int P    = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_load,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic                cfg_up,
  input  logic                cfg_reload,
  input  logic [W-1:0]        cfg_limit,
  input  logic [NUM_CH-1:0]   run,
  input  logic [NUM_CH-1:0]   clr_done,
  output logic                tick,
  output logic [NUM_CH*W-1:0] count,
  output logic [NUM_CH-1:0]   expire,
  output logic [NUM_CH-1:0]   done
);

  localparam logic [P-1:0] PRE_LAST = P'(CLKS_PER_TICK - 1);
  localparam logic [W:0]   MAX_EXT  = (W+1)'(MAX_COUNT);

  logic [P-1:0] pre_q;
  logic [W-1:0] lim_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q <= '0;
      tick  <= 1'b0;
    end else if (pre_q == PRE_LAST) begin
      pre_q <= '0;
      tick  <= 1'b1;
    end else begin
      pre_q <= pre_q + 1'b1;
      tick  <= 1'b0;
    end
  end

  // widen before comparing so a power-of-two range does not fold
  assign lim_in = ({1'b0, cfg_limit} > MAX_EXT) ? W'(MAX_COUNT)
                                                : cfg_limit;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic         up_q;
    logic         rld_q;
    logic         exp_q;
    logic         done_q;
    logic [W-1:0] lim_q;
    logic [W-1:0] cnt_q;
    logic [W-1:0] start;
    logic [W-1:0] term;
    logic [W-1:0] nxt;
    logic         load;
    logic         step;
    logic         at_term;

    assign load    = cfg_load && (cfg_ch == CH_W'(i));
    assign step    = tick && run[i];
    assign start   = up_q ? '0 : lim_q;
    assign term    = up_q ? lim_q : '0;
    assign at_term = (cnt_q == term);
    assign nxt     = up_q ? cnt_q + 1'b1 : cnt_q - 1'b1;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        up_q   <= 1'b1;
        rld_q  <= 1'b0;
        lim_q  <= W'(MAX_COUNT);
        cnt_q  <= '0;
        exp_q  <= 1'b0;
        done_q <= 1'b0;
      end else if (load) begin
        up_q   <= cfg_up;
        rld_q  <= cfg_reload;
        lim_q  <= lim_in;
        cnt_q  <= cfg_up ? '0 : lim_in;
        exp_q  <= 1'b0;
        done_q <= 1'b0;
      end else begin
        exp_q <= 1'b0;
        if (clr_done[i]) done_q <= 1'b0;
        // later set overrides the clear above
        if (step) begin
          unique case (1'b1)
            !at_term: begin
              cnt_q <= nxt;
              if (nxt == term) begin
                exp_q  <= 1'b1;
                done_q <= 1'b1;
              end
            end
            at_term && rld_q: begin
              cnt_q <= start;
              if (lim_q == '0) begin
                exp_q  <= 1'b1;
                done_q <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end

    assign count[i*W +: W] = cnt_q;
    assign expire[i]       = exp_q;
    assign done[i]         = done_q;
  end

endmodule

// File: tb/tb_multi_channel_timer.sv
// Directed bench for multi_channel_timer: main 4-channel instance plus a
// single-channel instance with a one-clock tick and a clamping limit.
module tb_multi_channel_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_load = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic        cfg_up = 1'b0;
  logic        cfg_reload = 1'b0;
  logic [3:0]  cfg_limit = '0;
  logic [3:0]  run = '0;
  logic [3:0]  clr_done = '0;
  logic        tick;
  logic [15:0] count;
  logic [3:0]  expire;
  logic [3:0]  done;

  logic        b_cfg_load = 1'b0;
  logic [0:0]  b_cfg_ch = '0;
  logic        b_cfg_up = 1'b1;
  logic        b_cfg_reload = 1'b0;
  logic [3:0]  b_cfg_limit = 4'd14;
  logic [0:0]  b_run = 1'b1;
  logic [0:0]  b_clr = 1'b0;
  logic        b_tick;
  logic [3:0]  b_count;
  logic [0:0]  b_expire;
  logic [0:0]  b_done;

  int vectors = 0;
  int miscompares = 0;
  int n = 0;

  multi_channel_timer #(
    .NUM_CH(4), .MAX_COUNT(15), .CLKS_PER_TICK(4)
  ) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_ch(cfg_ch),
    .cfg_up(cfg_up), .cfg_reload(cfg_reload), .cfg_limit(cfg_limit),
    .run(run), .clr_done(clr_done), .tick(tick), .count(count),
    .expire(expire), .done(done)
  );

  multi_channel_timer #(
    .NUM_CH(1), .MAX_COUNT(12), .CLKS_PER_TICK(1)
  ) dut_b (
    .clk(clk), .reset(reset), .cfg_load(b_cfg_load), .cfg_ch(b_cfg_ch),
    .cfg_up(b_cfg_up), .cfg_reload(b_cfg_reload),
    .cfg_limit(b_cfg_limit), .run(b_run), .clr_done(b_clr),
    .tick(b_tick), .count(b_count), .expire(b_expire), .done(b_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go_to(input int t);
    while (n < t) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  function automatic logic [3:0] cnt(input int i);
    return count[i*4 +: 4];
  endfunction

  task automatic load(input int ch, input logic up, input logic rld,
                      input logic [3:0] lim);
    cfg_ch     = 2'(ch);
    cfg_up     = up;
    cfg_reload = rld;
    cfg_limit  = lim;
    cfg_load   = 1'b1;
  endtask

  initial begin
    #1;
    chk("rst_tick", 32'(tick), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_expire", 32'(expire), 0);
    chk("rst_done", 32'(done), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    n = 0;

    // free-running prescaler, nothing enabled on the main instance
    for (int k = 1; k <= 12; k++) begin
      go_to(k);
      chk($sformatf("tick_n%0d", k), 32'(tick), 32'(k % 4 == 0));
      if (k <= 3) chk($sformatf("b_tick_n%0d", k), 32'(b_tick), 1);
      if (k == 2) b_cfg_load = 1'b1;
      if (k == 3) begin
        b_cfg_load = 1'b0;
        chk("b_load_count", 32'(b_count), 0);
      end
    end
    chk("idle_count", 32'(count), 0);
    chk("idle_done", 32'(done), 0);
    chk("idle_expire", 32'(expire), 0);

    go_to(13);
    load(0, 1'b1, 1'b1, 4'd3);
    go_to(14);
    chk("ch0_loaded", 32'(cnt(0)), 0);
    load(1, 1'b0, 1'b0, 4'd2);
    run = 4'b0001;
    go_to(15);
    chk("ch1_loaded", 32'(cnt(1)), 2);
    load(3, 1'b1, 1'b1, 4'd0);
    run = 4'b0011;
    go_to(16);
    cfg_load = 1'b0;
    run = 4'b1011;
    chk("ch3_loaded", 32'(cnt(3)), 0);

    go_to(17);
    chk("t17_ch0", 32'(cnt(0)), 1);
    chk("t17_ch1", 32'(cnt(1)), 1);
    chk("t17_ch3", 32'(cnt(3)), 0);
    chk("t17_expire", 32'(expire), 32'b1000);
    chk("t17_done", 32'(done), 32'b1000);

    go_to(20);
    chk("b_clamped", 32'(b_count), 12);
    chk("b_done", 32'(b_done), 1);

    go_to(21);
    chk("t21_ch0", 32'(cnt(0)), 2);
    chk("t21_ch1", 32'(cnt(1)), 0);
    chk("t21_expire", 32'(expire), 32'b1010);
    go_to(22);
    chk("t22_expire", 32'(expire), 0);
    chk("t22_done", 32'(done), 32'b1010);

    go_to(25);
    chk("t25_ch0", 32'(cnt(0)), 3);
    chk("t25_ch1_hold", 32'(cnt(1)), 0);
    chk("t25_expire", 32'(expire), 32'b1001);

    go_to(29);
    chk("t29_ch0_wrap", 32'(cnt(0)), 0);
    chk("t29_expire", 32'(expire), 32'b1000);
    chk("t29_done", 32'(done), 32'b1011);
    clr_done = 4'b0010;
    go_to(30);
    clr_done = 4'b0000;
    chk("t30_done_clr", 32'(done), 32'b1001);
    run = 4'b0011;

    for (int k = 33; k <= 41; k += 4) begin
      go_to(k);
      chk($sformatf("paused_exp3_n%0d", k), 32'(expire[3]), 0);
      chk($sformatf("paused_cnt3_n%0d", k), 32'(cnt(3)), 0);
      chk($sformatf("ch0_n%0d", k), 32'(cnt(0)), 32'((k - 29) / 4));
    end
    chk("t41_exp0", 32'(expire[0]), 1);
    run = 4'b1011;

    // load ch2 on the same edge that carries a tick
    go_to(44);
    chk("t44_tick", 32'(tick), 1);
    load(2, 1'b1, 1'b0, 4'd15);
    run = 4'b1111;
    go_to(45);
    cfg_load = 1'b0;
    chk("t45_ch2_noStep", 32'(cnt(2)), 0);
    chk("t45_expire", 32'(expire), 32'b1000);
    chk("t45_ch0", 32'(cnt(0)), 0);
    go_to(49);
    chk("t49_ch2", 32'(cnt(2)), 1);

    go_to(104);
    chk("t104_ch2", 32'(cnt(2)), 14);
    clr_done = 4'b0100;
    go_to(105);
    clr_done = 4'b0000;
    chk("t105_ch2", 32'(cnt(2)), 15);
    chk("t105_exp2", 32'(expire[2]), 1);
    chk("t105_set_wins", 32'(done[2]), 1);
    go_to(109);
    chk("t109_ch2_hold", 32'(cnt(2)), 15);
    chk("t109_exp2", 32'(expire[2]), 0);
    clr_done = 4'b0100;
    go_to(110);
    clr_done = 4'b0000;
    chk("t110_done2", 32'(done[2]), 0);

    go_to(120);
    chk("pre_rst_tick", 32'(tick), 1);
    chk("pre_rst_ch0", 32'(cnt(0)), 2);
    chk("pre_rst_done", 32'(done), 32'b1001);
    #2 reset = 1'b0;
    #1;
    chk("async_tick", 32'(tick), 0);
    chk("async_count", 32'(count), 0);
    chk("async_done", 32'(done), 0);
    chk("async_expire", 32'(expire), 0);
    chk("async_b_count", 32'(b_count), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("held_count", 32'(count), 0);
    reset = 1'b1;
    n = 0;

    go_to(3);
    chk("rel_tick_n3", 32'(tick), 0);
    chk("rel_count_n3", 32'(count), 0);
    go_to(4);
    chk("rel_tick_n4", 32'(tick), 1);
    go_to(5);
    chk("rel_count_n5", 32'(count), 32'h1111);
    chk("rel_expire_n5", 32'(expire), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
